// File: rtl/free_slot_alloc.sv
// rtl/free_slot_alloc.sv - multi-port lowest-free-slot allocator over an occupancy bitmap.
// Define SLOT_ALLOC_BYPASS_EN to let slots released this cycle be re-granted in the same cycle.
module free_slot_alloc #(
    parameter int CW = 4,
    parameter int DW = 2**CW,
    parameter int AP = 2,
    parameter int RP = 2
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [AP-1:0]    alloc_req,
    output logic [AP-1:0]    alloc_gnt,
    output logic [AP*CW-1:0] alloc_idx,
    input  logic [RP-1:0]    rls_valid,
    input  logic [RP*CW-1:0] rls_idx,
    input  logic             flush,
    output logic [CW:0]      free_cnt,
    output logic             full,
    output logic             empty
);

    logic [DW-1:0] occ_q, occ_d;
    logic [DW-1:0] rls_mask;
    logic [DW-1:0] free_set;
    logic [DW-1:0] gnt_mask;
    logic [AP-1:0] gnt_raw;

    // Balanced binary tree of CW levels: returns {found, lowest set index}.
    function automatic logic [CW:0] first_set(input logic [DW-1:0] v);
        logic          vld [DW];
        logic [CW-1:0] pos [DW];
        for (int i = 0; i < DW; i++) begin
            vld[i] = v[i];
            pos[i] = CW'(i);
        end
        for (int l = 0; l < CW; l++) begin
            for (int i = 0; i < (DW >> (l + 1)); i++) begin
                pos[i] = vld[2*i] ? pos[2*i] : pos[2*i+1];
                vld[i] = vld[2*i] | vld[2*i+1];
            end
        end
        return {vld[0], pos[0]};
    endfunction

    always_comb begin
        rls_mask = '0;
        for (int p = 0; p < RP; p++) begin
            if (rls_valid[p]) begin
                rls_mask[rls_idx[p*CW +: CW]] = 1'b1;
            end
        end
    end

`ifdef SLOT_ALLOC_BYPASS_EN
    assign free_set = ~occ_q | rls_mask;
`else
    assign free_set = ~occ_q;
`endif

    // Each port searches what the lower ports left behind, so grants stay in port order.
    always_comb begin
        logic [DW-1:0] avail;
        logic [CW:0]   hit;
        avail     = free_set;
        gnt_raw   = '0;
        gnt_mask  = '0;
        alloc_idx = '0;
        hit       = '0;
        for (int k = 0; k < AP; k++) begin
            hit = first_set(avail);
            if (alloc_req[k] && hit[CW]) begin
                gnt_raw[k]              = 1'b1;
                alloc_idx[k*CW +: CW]   = hit[CW-1:0];
                gnt_mask[hit[CW-1:0]]   = 1'b1;
                avail[hit[CW-1:0]]      = 1'b0;
            end
        end
    end

    assign alloc_gnt = gnt_raw & {AP{~flush & RSTn}};

    always_comb begin
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = (occ_q & ~rls_mask) | gnt_mask;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < DW; i++) begin
            free_cnt = free_cnt + {{CW{1'b0}}, ~occ_q[i]};
        end
    end

    assign full  = &occ_q;
    assign empty = ~|occ_q;

endmodule

// File: tb/tb_free_slot_alloc.sv
// tb/tb_free_slot_alloc.sv - randomized bench for free_slot_alloc against a queue-based model.
module tb_free_slot_alloc;
    localparam int CW = 3;
    localparam int DW = 8;
    localparam int AP = 2;
    localparam int RP = 2;

    logic            CLK = 1'b0;
    logic            RSTn;
    logic [AP-1:0]   alloc_req;
    logic [AP-1:0]   alloc_gnt;
    logic [AP*CW-1:0] alloc_idx;
    logic [RP-1:0]   rls_valid;
    logic [RP*CW-1:0] rls_idx;
    logic            flush;
    logic [CW:0]     free_cnt;
    logic            full;
    logic            empty;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_occ;
    logic [1:0] e_g, u_g;
    logic [5:0] e_ix, u_ix;
    logic [7:0] e_nxt, u_nxt;

    free_slot_alloc #(.CW(CW), .DW(DW), .AP(AP), .RP(RP)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
        .rls_valid(rls_valid), .rls_idx(rls_idx), .flush(flush),
        .free_cnt(free_cnt), .full(full), .empty(empty)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Free slots listed in ascending order; the j-th requesting port takes the j-th entry.
    task automatic model_alloc(input logic [7:0] occ, input logic [1:0] req,
                               input logic [1:0] rv, input logic [5:0] ri, input logic fl,
                               output logic [1:0] g, output logic [5:0] ix, output logic [7:0] nxt);
        int freeq[$];
        int j;
        int v;
        logic [7:0] rel;
        rel = '0;
        for (int p = 0; p < RP; p++) if (rv[p]) rel[ri[p*3 +: 3]] = 1'b1;
        for (int i = 0; i < DW; i++) begin
`ifdef SLOT_ALLOC_BYPASS_EN
            if (!occ[i] || rel[i]) freeq.push_back(i);
`else
            if (!occ[i]) freeq.push_back(i);
`endif
        end
        j = 0; g = '0; ix = '0;
        nxt = occ & ~rel;
        for (int k = 0; k < AP; k++) begin
            if (req[k]) begin
                if (!fl && j < freeq.size()) begin
                    v = freeq[j];
                    g[k] = 1'b1;
                    ix[k*3 +: 3] = 3'(v);
                    nxt[v] = 1'b1;
                end
                j++;
            end
        end
        if (fl) nxt = '0;
    endtask

    always @(negedge CLK) begin
        if (RSTn) begin
            model_alloc(model_occ, alloc_req, rls_valid, rls_idx, flush, e_g, e_ix, e_nxt);
            chk("gnt", int'(alloc_gnt), int'(e_g));
            for (int k = 0; k < AP; k++)
                if (e_g[k]) chk($sformatf("idx%0d", k), int'(alloc_idx[k*3 +: 3]), int'(e_ix[k*3 +: 3]));
            chk("free_cnt", int'(free_cnt), DW - $countones(model_occ));
            chk("full", int'(full), int'(model_occ == 8'hFF));
            chk("empty", int'(empty), int'(model_occ == 8'h00));
        end
    end

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            model_occ <= '0;
        end else begin
            model_alloc(model_occ, alloc_req, rls_valid, rls_idx, flush, u_g, u_ix, u_nxt);
            model_occ <= u_nxt;
        end
    end

    task automatic apply(input logic [1:0] rq, input logic [1:0] rv, input int r0, input int r1, input logic fl);
        @(posedge CLK);
        #1;
        alloc_req = rq;
        rls_valid = rv;
        rls_idx   = {3'(r1), 3'(r0)};
        flush     = fl;
        #2;
    endtask

    initial begin
        RSTn = 1'b0; alloc_req = 2'b11; rls_valid = '0; rls_idx = '0; flush = 1'b0;
        #2;
        chk("rst_gnt", int'(alloc_gnt), 0);
        chk("rst_free_cnt", int'(free_cnt), 8);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        alloc_req = 2'b00;
        #10;
        RSTn = 1'b1;

        apply(2'b11, 2'b00, 0, 0, 1'b0);
        chk("first_gnt", int'(alloc_gnt), 3);
        chk("first_idx0", int'(alloc_idx[2:0]), 0);
        chk("first_idx1", int'(alloc_idx[5:3]), 1);
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        chk("after_first_free_cnt", int'(free_cnt), 6);
        chk("second_idx0", int'(alloc_idx[2:0]), 2);
        chk("second_idx1", int'(alloc_idx[5:3]), 3);
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        apply(2'b00, 2'b01, 0, 0, 1'b0);
        chk("all_full", int'(full), 1);
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        chk("fe_free_cnt", int'(free_cnt), 1);
        chk("fe_gnt", int'(alloc_gnt), 1);
        chk("fe_idx0", int'(alloc_idx[2:0]), 0);
        apply(2'b00, 2'b00, 0, 0, 1'b0);
        chk("fe_next_full", int'(full), 1);
        chk("fe_next_free_cnt", int'(free_cnt), 0);

        apply(2'b01, 2'b01, 5, 0, 1'b0);
`ifdef SLOT_ALLOC_BYPASS_EN
        chk("bypass_gnt", int'(alloc_gnt), 1);
        chk("bypass_idx0", int'(alloc_idx[2:0]), 5);
        apply(2'b00, 2'b00, 0, 0, 1'b0);
        chk("bypass_free_cnt", int'(free_cnt), 0);
`else
        chk("nobypass_gnt", int'(alloc_gnt), 0);
        apply(2'b00, 2'b00, 0, 0, 1'b0);
        chk("nobypass_free_cnt", int'(free_cnt), 1);
        apply(2'b01, 2'b00, 0, 0, 1'b0);
        chk("refill_gnt", int'(alloc_gnt), 1);
        chk("refill_idx0", int'(alloc_idx[2:0]), 5);
`endif

        apply(2'b11, 2'b01, 3, 0, 1'b1);
        chk("flush_gnt", int'(alloc_gnt), 0);
        apply(2'b10, 2'b00, 0, 0, 1'b0);
        chk("flush_free_cnt", int'(free_cnt), 8);
        chk("flush_empty", int'(empty), 1);
        chk("compact_gnt", int'(alloc_gnt), 2);
        chk("compact_idx1", int'(alloc_idx[5:3]), 0);

        apply(2'b11, 2'b00, 0, 0, 1'b0);
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        apply(2'b01, 2'b00, 0, 0, 1'b0);
        apply(2'b00, 2'b11, 0, 1, 1'b0);
        apply(2'b00, 2'b11, 3, 3, 1'b0);
        chk("occ_3c_free_cnt", int'(free_cnt), 4);
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        chk("dup_rls_free_cnt", int'(free_cnt), 5);
        chk("dup_rls_idx0", int'(alloc_idx[2:0]), 0);
        chk("dup_rls_idx1", int'(alloc_idx[5:3]), 1);
        apply(2'b11, 2'b00, 0, 0, 1'b0);
        chk("dup_rls_idx0b", int'(alloc_idx[2:0]), 3);
        chk("dup_rls_idx1b", int'(alloc_idx[5:3]), 6);

        #1;
        RSTn = 1'b0;
        #1;
        chk("async_rst_gnt", int'(alloc_gnt), 0);
        chk("async_rst_free_cnt", int'(free_cnt), 8);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_full", int'(full), 0);
        @(negedge CLK);
        #1;
        RSTn = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            apply(2'($urandom), 2'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);
        end
        apply(2'b00, 2'b00, 0, 0, 1'b0);
        @(posedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
